mcu_shiftin: RTL and testbench
==============================

MCU_SHIFTIN -- requirements
Module: mcu_shiftin

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000, SHALL set the system_clock cycles without a valid frame before the link is declared lost (100 ms at 20 MHz).
REQ-002 Parameter SYNC_NIBBLE, default 4'hA, SHALL be the required frame header.
REQ-003 Parameter IDLE_BUTTONS, default 12'hFFF, SHALL be the all-released, active-low button word.
REQ-004 system_clock  input  1  sole clock, 20 MHz.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mcu_sclk  input  1  serial clock from the USB host MCU, asynchronous to system_clock.
REQ-007 mcu_mosi  input  1  serial data from the MCU, MSB first, valid on mcu_sclk rising edge.
REQ-008 mcu_cs_n  input  1  active-low frame select from the MCU.
REQ-009 shiftout_in  output  12  registered active-low button word; feeds multiout.shiftout_in.
REQ-010 link_ok  output  1  high while a valid frame has arrived within TIMEOUT_CYCLES.
REQ-011 frame_valid  output  1  one-cycle pulse when a frame is accepted.
REQ-012 frame_error  output  1  one-cycle pulse when a frame is rejected.

Function
REQ-013 mcu_sclk, mcu_mosi and mcu_cs_n SHALL each pass through a two-flop synchronizer before use.
REQ-014 A rising edge of synchronized mcu_sclk while synchronized mcu_cs_n is low SHALL shift synchronized mcu_mosi into a 16-bit shift register LSB-side, within 3 cycles of the pin edge.
REQ-015 Supported mcu_sclk rate SHALL be up to system_clock/8, minimum high and low time 4 cycles each.
REQ-016 Frame format SHALL be 16 bits: [15:12] header, [11:0] buttons, bit 11 first after header.
REQ-017 FSM states SHALL be IDLE, RECEIVE, CHECK.
REQ-018 IDLE -> RECEIVE on synchronized mcu_cs_n falling edge; shift register and 5-bit bit counter cleared on entry.
REQ-019 RECEIVE -> CHECK on synchronized mcu_cs_n rising edge; bit counter saturates at 17.
REQ-020 CHECK SHALL last exactly one cycle, then return to IDLE.
REQ-021 In CHECK, bit count == 16 and header == SYNC_NIBBLE SHALL accept: shiftout_in loaded with bits [11:0] and frame_valid pulsed on the cycle after CHECK.
REQ-022 In CHECK, any other count or header SHALL reject: frame_error pulsed on the cycle after CHECK, shiftout_in unchanged.
REQ-023 shiftout_in SHALL change only on acceptance or timeout, never mid-frame.
REQ-024 Watchdog counter SHALL clear on acceptance and otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-025 On reaching TIMEOUT_CYCLES, shiftout_in SHALL load IDLE_BUTTONS and link_ok SHALL drop, same cycle.
REQ-026 link_ok SHALL rise on the cycle shiftout_in loads an accepted frame.
REQ-027 Acceptance and timeout in the same cycle SHALL resolve in favour of acceptance.
REQ-028 mcu_sclk edges while mcu_cs_n is high SHALL be ignored.

Reset
REQ-029 reset SHALL asynchronously force: shiftout_in = IDLE_BUTTONS, link_ok = 0, frame_valid = 0, frame_error = 0, FSM = IDLE, counters and shift register = 0, synchronizer flops = idle levels (sclk 0, mosi 0, cs_n 1).
REQ-030 reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL begin on a fresh mcu_cs_n falling edge.

Structure
REQ-031 FSM state encoding, default SYNC_NIBBLE, IDLE_BUTTONS and FRAME_BITS (16) SHALL live in shared package mcu_shiftin_pkg.
REQ-032 The two-flop synchronizer SHALL be a sub-module sync2 with reset value parameter, instantiated three times.
REQ-033 Implementation target SHALL be 120-400 lines of RTL.

Verification
REQ-034 Frame 16'hAFAF at sclk = 1 MHz -> frame_valid pulse, shiftout_in = 12'hFAF, link_ok = 1.
REQ-035 Frame 16'h5FAF (bad header) after REQ-034 -> frame_error pulse, shiftout_in stays 12'hFAF.
REQ-036 15-bit and 17-bit frames -> frame_error each, shiftout_in unchanged.
REQ-037 TIMEOUT_CYCLES = 1000, one valid frame 12'h0F0, then silence -> at cycle 1000 after acceptance shiftout_in = 12'hFFF, link_ok = 0.
REQ-038 reset pulsed after 8 bits of a frame -> outputs at reset values; next full valid frame 16'hA123 accepted, shiftout_in = 12'h123.
REQ-039 sclk toggled 20 times with cs_n high -> no pulses, shiftout_in unchanged.

Source files
------------

// File: rtl/mcu_shiftin_pkg.sv
// mcu_shiftin shared definitions: FSM encoding,
// frame geometry and default header/idle words.
package mcu_shiftin_pkg;

   localparam int FRAME_BITS = 16;
   localparam int CNT_W = 5;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);

   localparam logic [3:0] SYNC_NIBBLE_DEF = 4'hA;
   localparam logic [11:0] IDLE_BUTTONS_DEF = 12'hFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

endpackage

// File: rtl/mcu_shiftin_sync2.sv
// Two-flop synchronizer for one asynchronous pin,
// with a selectable reset level.
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input logic clk_i,
   input logic rst_i,
   input logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   // shift the pin through two flops
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ff_q <= {2{RST_VAL}};
      else ff_q <= {ff_q[0], d_i};
   end

   assign q_o = ff_q[1];

endmodule

// File: rtl/mcu_shiftin.sv
// Serial button-frame receiver from the host MCU
// with header check and link watchdog.
module mcu_shiftin
   import mcu_shiftin_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter logic [3:0] SYNC_NIBBLE = SYNC_NIBBLE_DEF,
   parameter logic [11:0] IDLE_BUTTONS = IDLE_BUTTONS_DEF
) (
   input logic system_clock,
   input logic reset,
   input logic mcu_sclk,
   input logic mcu_mosi,
   input logic mcu_cs_n,
   output logic [11:0] shiftout_in,
   output logic link_ok,
   output logic frame_valid,
   output logic frame_error
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic sclk_s, mosi_s, csn_s;
   logic sclk_q, csn_q;
   logic sclk_rise, cs_fall, cs_rise;

   state_e state_q, state_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [11:0] shout_q, shout_d;
   logic link_q, link_d;
   logic fv_q, fe_q;
   logic accept, reject, timeout;

   sync2 #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk_i(system_clock),
      .rst_i(reset),
      .d_i(mcu_sclk),
      .q_o(sclk_s)
   );

   sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(system_clock),
      .rst_i(reset),
      .d_i(mcu_mosi),
      .q_o(mosi_s)
   );

   sync2 #(.RST_VAL(1'b1)) u_sync_csn (
      .clk_i(system_clock),
      .rst_i(reset),
      .d_i(mcu_cs_n),
      .q_o(csn_s)
   );

   assign sclk_rise = sclk_s & ~sclk_q;
   assign cs_fall = ~csn_s & csn_q;
   assign cs_rise = csn_s & ~csn_q;

   // frame FSM: open on select, shift bits, judge once
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d = cnt_q;
      accept = 1'b0;
      reject = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_RECEIVE;
               shreg_d = '0;
               cnt_d = '0;
            end
         end
         ST_RECEIVE: begin
            if (cs_rise) begin
               state_d = ST_CHECK;
            end else if (sclk_rise && !csn_s) begin
               shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_s};
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            if (cnt_q == CNT_FULL &&
                shreg_q[15:12] == SYNC_NIBBLE)
               accept = 1'b1;
            else
               reject = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // watchdog and button word; acceptance beats timeout
   always_comb begin
      timeout = (wd_q == WD_LAST);
      wd_d = wd_q;
      shout_d = shout_q;
      link_d = link_q;
      if (accept) wd_d = '0;
      else if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
      if (accept) begin
         shout_d = shreg_q[11:0];
         link_d = 1'b1;
      end else if (timeout) begin
         shout_d = IDLE_BUTTONS;
         link_d = 1'b0;
      end
   end

   // state and datapath registers
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         sclk_q <= 1'b0;
         csn_q <= 1'b1;
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q <= '0;
         wd_q <= '0;
         shout_q <= IDLE_BUTTONS;
         link_q <= 1'b0;
         fv_q <= 1'b0;
         fe_q <= 1'b0;
      end else begin
         sclk_q <= sclk_s;
         csn_q <= csn_s;
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q <= cnt_d;
         wd_q <= wd_d;
         shout_q <= shout_d;
         link_q <= link_d;
         fv_q <= accept;
         fe_q <= reject;
      end
   end

   assign shiftout_in = shout_q;
   assign link_ok = link_q;
   assign frame_valid = fv_q;
   assign frame_error = fe_q;

endmodule

// File: tb/tb_mcu_shiftin.sv
// Bench for mcu_shiftin: transaction-level model
// predicting pulses, button word and link timeout.
module tb_mcu_shiftin;

   localparam int TO = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk = 1'b0;
   logic mosi = 1'b0;
   logic csn = 1'b1;
   logic [11:0] shout;
   logic link, fv, fe;

   mcu_shiftin #(.TIMEOUT_CYCLES(TO)) dut (
      .system_clock(clk),
      .reset(rst),
      .mcu_sclk(sclk),
      .mcu_mosi(mosi),
      .mcu_cs_n(csn),
      .shiftout_in(shout),
      .link_ok(link),
      .frame_valid(fv),
      .frame_error(fe)
   );

   // 20 MHz system clock
   always #25 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // pending frame outcome, written by stimulus only
   int ev_cyc = -1;
   logic ev_acc = 1'b0;
   logic [11:0] ev_val = '0;

   // literal pin request
   logic pin_on = 1'b0;
   string pin_name = "";
   logic [11:0] pin_shout = '0;
   logic pin_link = 1'b0;
   int pin_fv = 0;
   int pin_fe = 0;

   // model state and counters
   int base = 0;
   logic [11:0] m_shout = 12'hFFF;
   logic m_link = 1'b0;
   int fv_cnt = 0;
   int fe_cnt = 0;
   int n_cmp = 0;
   int n_bad = 0;

   always @(negedge clk) begin : cmp
      logic m_fv, m_fe;
      m_fv = 1'b0;
      m_fe = 1'b0;
      if (rst) begin
         m_shout = 12'hFFF;
         m_link = 1'b0;
         base = cyc;
      end else begin
         if (cyc == base + TO) begin
            m_shout = 12'hFFF;
            m_link = 1'b0;
         end
         if (cyc == ev_cyc) begin
            if (ev_acc) begin
               m_shout = ev_val;
               m_link = 1'b1;
               m_fv = 1'b1;
               base = cyc;
            end else begin
               m_fe = 1'b1;
            end
         end
      end
      if (fv === 1'b1) fv_cnt++;
      if (fe === 1'b1) fe_cnt++;
      n_cmp++;
      if ({shout, link, fv, fe} !== {m_shout, m_link, m_fv, m_fe}) begin
         n_bad++;
         $display("FAIL cycle %0d: got shiftout_in=%h link_ok=%b valid=%b error=%b, required %h %b %b %b",
                  cyc, shout, link, fv, fe, m_shout, m_link, m_fv, m_fe);
      end
      if (pin_on) begin
         n_cmp++;
         if (shout !== pin_shout || link !== pin_link ||
             fv_cnt != pin_fv || fe_cnt != pin_fe) begin
            n_bad++;
            $display("FAIL %s: got shiftout_in=%h link_ok=%b valid_pulses=%0d error_pulses=%0d, required %h %b %0d %0d",
                     pin_name, shout, link, fv_cnt, fe_cnt,
                     pin_shout, pin_link, pin_fv, pin_fe);
         end
         n_cmp++;
         if (m_shout !== pin_shout || m_link !== pin_link) begin
            n_bad++;
            $display("FAIL %s model: got %h %b, required %h %b",
                     pin_name, m_shout, m_link, pin_shout, pin_link);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pin(input string nm, input logic [11:0] s,
                      input logic l, input int f, input int e);
      pin_name = nm;
      pin_shout = s;
      pin_link = l;
      pin_fv = f;
      pin_fe = e;
      pin_on = 1'b1;
      @(negedge clk);
      #1;
      pin_on = 1'b0;
   endtask

   task automatic send_frame(input logic [16:0] bits, input int nb,
                             input int hp, input int rise_at);
      csn = 1'b0;
      sclk = 1'b0;
      tick(hp);
      for (int i = nb - 1; i >= 0; i--) begin
         mosi = bits[i];
         tick(hp);
         sclk = 1'b1;
         tick(hp);
         sclk = 1'b0;
      end
      tick(hp);
      while (cyc < rise_at) tick(1);
      csn = 1'b1;
      ev_acc = (nb == 16) && (bits[15:12] == 4'hA);
      ev_val = bits[11:0];
      ev_cyc = cyc + 4;
      tick(8);
   endtask

   initial begin : stim
      int acc_at;
      logic [16:0] b;
      int nb, hp, g, r;
      rst = 1'b1;
      tick(4);
      rst = 1'b0;
      tick(2);
      pin("reset_state", 12'hFFF, 1'b0, 0, 0);

      send_frame(17'h0AFAF, 16, 10, 0);
      pin("frame_AFAF", 12'hFAF, 1'b1, 1, 0);
      send_frame(17'h05FAF, 16, 4, 0);
      pin("bad_header", 12'hFAF, 1'b1, 1, 1);
      send_frame(17'h057D7, 15, 4, 0);
      pin("short_15", 12'hFAF, 1'b1, 1, 2);
      send_frame(17'h15F5E, 17, 4, 0);
      pin("long_17", 12'hFAF, 1'b1, 1, 3);

      for (int i = 0; i < 20; i++) begin
         mosi = 1'($urandom);
         sclk = ~sclk;
         tick(4);
      end
      sclk = 1'b0;
      tick(4);
      pin("sclk_cs_high", 12'hFAF, 1'b1, 1, 3);

      send_frame(17'h0A0F0, 16, 4, 0);
      acc_at = ev_cyc;
      pin("frame_A0F0", 12'h0F0, 1'b1, 2, 3);
      while (cyc < acc_at + TO - 2) tick(1);
      pin("pre_timeout", 12'h0F0, 1'b1, 2, 3);
      pin("timeout", 12'hFFF, 1'b0, 2, 3);

      tick(20);
      send_frame(17'h0A555, 16, 4, 0);
      acc_at = ev_cyc;
      pin("frame_A555", 12'h555, 1'b1, 3, 3);
      send_frame(17'h0AABC, 16, 5, acc_at + TO - 4);
      pin("accept_beats_timeout", 12'hABC, 1'b1, 4, 3);

      csn = 1'b0;
      tick(6);
      for (int i = 7; i >= 0; i--) begin
         mosi = 1'(8'hA1 >> i);
         tick(5);
         sclk = 1'b1;
         tick(5);
         sclk = 1'b0;
      end
      rst = 1'b1;
      csn = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      pin("reset_mid_frame", 12'hFFF, 1'b0, 4, 3);
      tick(2);
      rst = 1'b0;
      tick(6);
      send_frame(17'h0A123, 16, 6, 0);
      pin("after_reset_A123", 12'h123, 1'b1, 5, 3);

      for (int k = 0; k < 40; k++) begin
         b = 17'($urandom);
         r = $urandom_range(0, 5);
         nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
         if ($urandom_range(0, 9) < 7) b[15:12] = 4'hA;
         hp = $urandom_range(4, 12);
         send_frame(b, nb, hp, 0);
         g = ($urandom_range(0, 7) == 0) ?
             $urandom_range(900, 1200) : $urandom_range(2, 60);
         tick(g);
      end

      tick(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
